// File: rtl/pos_tag_out_buffer.sv
// Output FIFO for Viterbi POS tags: buffers popped tags, marks the sentence-final tag, streams to host.
// Optional per-tag saturating histogram enabled by defining TAG_HISTOGRAM_EN.
module pos_tag_out_buffer #(
  parameter int POS_num     = 11,
  parameter int POS_num_bit = 4,
  parameter int DEPTH       = 16,
  parameter int DEPTH_BIT   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tag_valid_in,
  input  logic [POS_num_bit-1:0] tag_in,
  input  logic                   done_in,
  input  logic                   out_ready,
`ifdef TAG_HISTOGRAM_EN
  input  logic [POS_num_bit-1:0] hist_sel,
  output logic [7:0]             hist_count,
`endif
  output logic                   out_valid,
  output logic [POS_num_bit-1:0] out_tag,
  output logic                   out_last,
  output logic                   full,
  output logic                   empty,
  output logic [DEPTH_BIT:0]     count,
  output logic                   overflow,
  output logic                   bad_tag,
  output logic                   sentence_done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  localparam logic [DEPTH_BIT:0]   DEPTH_C   = DEPTH[DEPTH_BIT:0];
  localparam logic [POS_num_bit:0] POS_LIMIT = POS_num[POS_num_bit:0];

  state_t                 state_q, state_d;
  logic [POS_num_bit-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]       last_q;
  logic [DEPTH_BIT-1:0]   wr_ptr_q, rd_ptr_q;
  logic [DEPTH_BIT:0]     count_q, count_d;
  logic                   done_q;
  logic                   overflow_q, overflow_d;
  logic                   bad_tag_q, bad_tag_d;
  logic                   sentence_done_q, sentence_done_d;

  logic                   empty_w, full_w, pop, push_req, push_ok, done_rise;
  logic                   head_last, mark_new, mark_prev;
  logic [DEPTH_BIT-1:0]   prev_ptr;

  assign empty_w   = (count_q == '0);
  assign full_w    = (count_q == DEPTH_C);
  assign pop       = ~empty_w & out_ready;
  assign push_req  = tag_valid_in & (state_q != DRAIN);
  assign push_ok   = push_req & (~full_w | pop);
  assign done_rise = done_in & ~done_q;
  assign head_last = last_q[rd_ptr_q];
  assign prev_ptr  = wr_ptr_q - DEPTH_BIT'(1);

  assign out_valid     = ~empty_w;
  assign out_tag       = empty_w ? '0 : mem_q[rd_ptr_q];
  assign out_last      = ~empty_w & head_last;
  assign full          = full_w;
  assign empty         = empty_w;
  assign count         = count_q;
  assign overflow      = overflow_q;
  assign bad_tag       = bad_tag_q;
  assign sentence_done = sentence_done_q;

  always_comb begin
    state_d         = state_q;
    sentence_done_d = 1'b0;
    mark_new        = 1'b0;
    mark_prev       = 1'b0;
    case (state_q)
      IDLE: begin
        if (push_ok && done_rise) begin
          mark_new = 1'b1;
          state_d  = DRAIN;
        end else if (push_ok) begin
          state_d = COLLECT;
        end else if (done_rise && empty_w) begin
          sentence_done_d = 1'b1;
        end
      end
      COLLECT: begin
        if (done_rise) begin
          if (push_ok) begin
            mark_new = 1'b1;
            state_d  = DRAIN;
          end else if (count_q > {{DEPTH_BIT{1'b0}}, pop}) begin
            mark_prev = 1'b1;
            state_d   = DRAIN;
          end else begin
            // The only remaining entry leaves this cycle, so there is nothing left to flag.
            sentence_done_d = 1'b1;
            state_d         = IDLE;
          end
        end
      end
      DRAIN: begin
        if (pop && head_last) begin
          sentence_done_d = 1'b1;
          state_d         = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + (DEPTH_BIT+1)'(1);
      2'b01:   count_d = count_q - (DEPTH_BIT+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    overflow_d = overflow_q;
    bad_tag_d  = bad_tag_q;
    if ((push_req && !push_ok) || (tag_valid_in && state_q == DRAIN)) begin
      overflow_d = 1'b1;
    end
    if (push_ok && ({1'b0, tag_in} >= POS_LIMIT)) begin
      bad_tag_d = 1'b1;
    end
  end

  // Tag payload lives in plain storage; the last flags sit in flops so the previous entry can be marked later.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= tag_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= '0;
    end else begin
      if (push_ok) begin
        last_q[wr_ptr_q] <= mark_new;
      end
      if (mark_prev) begin
        last_q[prev_ptr] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      done_q          <= 1'b0;
      overflow_q      <= 1'b0;
      bad_tag_q       <= 1'b0;
      sentence_done_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      count_q         <= count_d;
      done_q          <= done_in;
      overflow_q      <= overflow_d;
      bad_tag_q       <= bad_tag_d;
      sentence_done_q <= sentence_done_d;
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + DEPTH_BIT'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + DEPTH_BIT'(1);
      end
    end
  end

`ifdef TAG_HISTOGRAM_EN
  logic [POS_num*8-1:0] hist_flat;

  genvar gi;
  generate
    for (gi = 0; gi < POS_num; gi++) begin : g_hist
      logic [7:0] cnt_q;
      logic       hit;

      assign hit = push_ok && (tag_in == POS_num_bit'(gi));

      // The clear lands on the edge that ends the pulse cycle; a push on that same edge starts the new count.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cnt_q <= '0;
        end else if (sentence_done_q) begin
          cnt_q <= hit ? 8'd1 : 8'd0;
        end else if (hit && cnt_q != 8'hFF) begin
          cnt_q <= cnt_q + 8'd1;
        end
      end

      assign hist_flat[gi*8 +: 8] = cnt_q;
    end
  endgenerate

  always_comb begin
    hist_count = '0;
    for (int i = 0; i < POS_num; i++) begin
      if (hist_sel == i[POS_num_bit-1:0]) begin
        hist_count = hist_flat[i*8 +: 8];
      end
    end
  end
`endif

endmodule

// File: tb/tb_pos_tag_out_buffer.sv
// Directed bench for pos_tag_out_buffer; histogram checks compile only with TAG_HISTOGRAM_EN.
module tb_pos_tag_out_buffer;

  logic       clk = 1'b0;
  logic       reset;
  logic       tag_valid_in;
  logic [3:0] tag_in;
  logic       done_in;
  logic       out_ready;
  logic       out_valid;
  logic [3:0] out_tag;
  logic       out_last;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic       bad_tag;
  logic       sentence_done;
`ifdef TAG_HISTOGRAM_EN
  logic [3:0] hist_sel;
  logic [7:0] hist_count;
`endif

  int vectors     = 0;
  int miscompares = 0;

  pos_tag_out_buffer #(
    .POS_num(11), .POS_num_bit(4), .DEPTH(16), .DEPTH_BIT(4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .tag_valid_in (tag_valid_in),
    .tag_in       (tag_in),
    .done_in      (done_in),
    .out_ready    (out_ready),
`ifdef TAG_HISTOGRAM_EN
    .hist_sel     (hist_sel),
    .hist_count   (hist_count),
`endif
    .out_valid    (out_valid),
    .out_tag      (out_tag),
    .out_last     (out_last),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .overflow     (overflow),
    .bad_tag      (bad_tag),
    .sentence_done(sentence_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
      else begin
        miscompares++;
        $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
    $display("vec %0d %s observed=%0d expected=%0d", vectors, tag, observed, expected);
  endtask

  task automatic do_reset();
    tag_valid_in = 1'b0;
    tag_in       = 4'd0;
    done_in      = 1'b0;
    out_ready    = 1'b0;
    reset        = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  logic [3:0] exp_tag;

  initial begin
`ifdef TAG_HISTOGRAM_EN
    hist_sel = 4'd0;
`endif
    do_reset();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);
    chk("rst_count", count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_bad_tag", bad_tag, 0);
    chk("rst_sentence_done", sentence_done, 0);

    // T1: 3,7,1 with done rising alongside the push of 1
    out_ready = 1'b1;
    tag_valid_in = 1'b1; tag_in = 4'd3;
    tick();
    chk("t1_valid0", out_valid, 1);
    chk("t1_tag0", out_tag, 3);
    chk("t1_last0", out_last, 0);
    tag_in = 4'd7;
    tick();
    chk("t1_tag1", out_tag, 7);
    chk("t1_last1", out_last, 0);
    chk("t1_count1", count, 1);
    tag_in = 4'd1; done_in = 1'b1;
    tick();
    chk("t1_tag2", out_tag, 1);
    chk("t1_last2", out_last, 1);
    chk("t1_sd_early", sentence_done, 0);
    tag_valid_in = 1'b0;
    tick();
    chk("t1_sd_pulse", sentence_done, 1);
    chk("t1_empty", empty, 1);
    done_in = 1'b0;
    tick();
    chk("t1_sd_drop", sentence_done, 0);
    out_ready = 1'b0;

    // T2: fill to 16, drop the 17th, drain in order
    do_reset();
    tag_valid_in = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tag_in = 4'(i % 11);
      tick();
    end
    chk("t2_full", full, 1);
    chk("t2_count16", count, 16);
    chk("t2_no_ovf", overflow, 0);
    tag_in = 4'd9;
    tick();
    chk("t2_ovf", overflow, 1);
    chk("t2_count_hold", count, 16);
    tag_valid_in = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("t2_drain_tag", out_tag, 32'(i % 11));
      tick();
    end
    chk("t2_empty", empty, 1);
    chk("t2_bad_tag", bad_tag, 0);
    out_ready = 1'b0;

    // T3: push and pop together on a full FIFO
    do_reset();
    tag_valid_in = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tag_in = 4'(i % 11);
      tick();
    end
    tag_in = 4'd6; out_ready = 1'b1;
    tick();
    chk("t3_count", count, 16);
    chk("t3_full", full, 1);
    chk("t3_no_ovf", overflow, 0);
    tag_valid_in = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp_tag = (i == 15) ? 4'd6 : 4'((i + 1) % 11);
      chk("t3_drain_tag", out_tag, exp_tag);
      tick();
    end
    chk("t3_empty", empty, 1);
    out_ready = 1'b0;

    // T4: out-of-range tag, then async reset clears it
    do_reset();
    tag_valid_in = 1'b1; tag_in = 4'd12;
    tick();
    tag_valid_in = 1'b0;
    chk("t4_bad_tag", bad_tag, 1);
    chk("t4_out_tag", out_tag, 12);
    chk("t4_valid", out_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("t4_rst_bad_tag", bad_tag, 0);
    chk("t4_rst_empty", empty, 1);
    tick();
    reset = 1'b0;

    // T5: done on an empty idle FIFO, then a push during DRAIN
    done_in = 1'b1;
    tick();
    chk("t5_sd_pulse", sentence_done, 1);
    chk("t5_valid", out_valid, 0);
    done_in = 1'b0;
    tick();
    chk("t5_sd_drop", sentence_done, 0);
    tag_valid_in = 1'b1; tag_in = 4'd5;
    tick();
    tag_valid_in = 1'b0; done_in = 1'b1;
    tick();
    chk("t5_last_marked", out_last, 1);
    tag_valid_in = 1'b1; tag_in = 4'd2;
    tick();
    tag_valid_in = 1'b0;
    chk("t5_drain_ovf", overflow, 1);
    chk("t5_drain_count", count, 1);
    chk("t5_head_tag", out_tag, 5);
    out_ready = 1'b1;
    tick();
    chk("t5_sd_after_drain", sentence_done, 1);
    chk("t5_empty", empty, 1);
    out_ready = 1'b0; done_in = 1'b0;
    tick();

`ifdef TAG_HISTOGRAM_EN
    // T6: histogram counts, clear after sentence_done, saturation
    do_reset();
    out_ready = 1'b1; tag_valid_in = 1'b1;
    tag_in = 4'd2; tick();
    tag_in = 4'd2; tick();
    tag_in = 4'd5; tick();
    tag_valid_in = 1'b0;
    hist_sel = 4'd2; #1;
    chk("t6_hist2", hist_count, 2);
    hist_sel = 4'd5; #1;
    chk("t6_hist5", hist_count, 1);
    hist_sel = 4'd12; #1;
    chk("t6_hist_oob", hist_count, 0);
    done_in = 1'b1;
    tick();
    chk("t6_sd_pulse", sentence_done, 1);
    hist_sel = 4'd2; #1;
    chk("t6_hist2_in_pulse", hist_count, 2);
    tick();
    chk("t6_hist2_clr", hist_count, 0);
    hist_sel = 4'd5; #1;
    chk("t6_hist5_clr", hist_count, 0);
    done_in = 1'b0;
    tag_valid_in = 1'b1; tag_in = 4'd4;
    for (int i = 0; i < 300; i++) begin
      tick();
    end
    tag_valid_in = 1'b0;
    hist_sel = 4'd4; #1;
    chk("t6_hist4_sat", hist_count, 255);
    out_ready = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
